// File: rtl/mem_access_arbiter_if.sv
// Bundle of requester, internal-RAM and external-controller signals around the
// memory access arbiter; slave is the arbiter's view, master the environment's.
interface mem_access_arbiter_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH_EXT = 20,
    parameter int INT_DEPTH      = 256
);
    localparam int RAM_AW = $clog2(INT_DEPTH);

    logic                      cpu_req;
    logic                      cpu_we;
    logic [ADDR_WIDTH_EXT-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0]     cpu_wdata;
    logic                      cpu_ack;
    logic [DATA_WIDTH-1:0]     cpu_rdata;

    logic                      alu_req;
    logic                      alu_we;
    logic [ADDR_WIDTH_EXT-1:0] alu_addr;
    logic [DATA_WIDTH-1:0]     alu_wdata;
    logic                      alu_ack;
    logic [DATA_WIDTH-1:0]     alu_rdata;

    logic                      ram_we;
    logic                      ram_re;
    logic [RAM_AW-1:0]         ram_addr;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    logic                      spi_start;
    logic                      spi_we;
    logic [ADDR_WIDTH_EXT-1:0] spi_addr;
    logic [DATA_WIDTH-1:0]     spi_wdata;
    logic                      spi_done;
    logic [DATA_WIDTH-1:0]     spi_rdata;

    logic                      ack_err;
    logic                      busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  alu_req, alu_we, alu_addr, alu_wdata,
        output alu_ack, alu_rdata,
        output ram_we, ram_re, ram_addr, ram_wdata,
        input  ram_rdata,
        output spi_start, spi_we, spi_addr, spi_wdata,
        input  spi_done, spi_rdata,
        output ack_err, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output alu_req, alu_we, alu_addr, alu_wdata,
        input  alu_ack, alu_rdata,
        input  ram_we, ram_re, ram_addr, ram_wdata,
        output ram_rdata,
        input  spi_start, spi_we, spi_addr, spi_wdata,
        output spi_done, spi_rdata,
        input  ack_err, busy
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter giving a CPU and an ALU sequencer single-access turns at
// an internal synchronous RAM or an external (SPI) memory with a done timeout.
module mem_access_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH_EXT = 20,
    parameter int INT_DEPTH      = 256,
    parameter int EXT_TIMEOUT    = 4096
) (
    input logic                clk,
    input logic                reset,
    mem_access_arbiter_if.slave bus
);
    localparam int RAM_AW = $clog2(INT_DEPTH);
    localparam int CNT_W  = $clog2(EXT_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH_EXT-1:0] INT_LIMIT = ADDR_WIDTH_EXT'(INT_DEPTH);

    typedef enum logic [2:0] {IDLE, RAM_ACC, RAM_RD, EXT_START, EXT_WAIT, ACK} state_t;

    state_t                    state, state_d;
    logic                      owner_alu, last_alu, grant_alu, timeout_hit;
    logic                      we_q, err_q;
    logic [ADDR_WIDTH_EXT-1:0] addr_q, grant_addr;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [DATA_WIDTH-1:0]     cpu_rdata_q, alu_rdata_q;
    logic [CNT_W-1:0]          cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d     = state;
        // On a tie the requester that was not served last goes first.
        grant_alu   = bus.alu_req && (!bus.cpu_req || !last_alu);
        grant_addr  = grant_alu ? bus.alu_addr : bus.cpu_addr;
        timeout_hit = (cnt == CNT_W'(EXT_TIMEOUT - 1));
        case (state)
            IDLE:      if (bus.cpu_req || bus.alu_req)
                           state_d = (grant_addr < INT_LIMIT) ? RAM_ACC : EXT_START;
            RAM_ACC:   state_d = we_q ? ACK : RAM_RD;
            RAM_RD:    state_d = ACK;
            EXT_START: state_d = EXT_WAIT;
            EXT_WAIT:  if (bus.spi_done || timeout_hit) state_d = ACK;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_alu   <= 1'b0;
            last_alu    <= 1'b1;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            alu_rdata_q <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpu_req || bus.alu_req) begin
                    owner_alu <= grant_alu;
                    we_q      <= grant_alu ? bus.alu_we : bus.cpu_we;
                    addr_q    <= grant_addr;
                    wdata_q   <= grant_alu ? bus.alu_wdata : bus.cpu_wdata;
                    err_q     <= 1'b0;
                end
                RAM_RD: begin
                    if (owner_alu) alu_rdata_q <= bus.ram_rdata;
                    else           cpu_rdata_q <= bus.ram_rdata;
                end
                EXT_START: cnt <= '0;
                EXT_WAIT: begin
                    // A done pulse in the timeout cycle still counts as success.
                    if (bus.spi_done) begin
                        if (!we_q) begin
                            if (owner_alu) alu_rdata_q <= bus.spi_rdata;
                            else           cpu_rdata_q <= bus.spi_rdata;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        if (owner_alu) alu_rdata_q <= '0;
                        else           cpu_rdata_q <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ACK: last_alu <= owner_alu;
                default: ;
            endcase
        end
    end

    assign bus.cpu_ack   = (state == ACK) && !owner_alu;
    assign bus.alu_ack   = (state == ACK) && owner_alu;
    assign bus.ack_err   = (state == ACK) && err_q;
    assign bus.busy      = (state != IDLE);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.alu_rdata = alu_rdata_q;
    assign bus.ram_we    = (state == RAM_ACC) && we_q;
    assign bus.ram_re    = (state == RAM_ACC) && !we_q;
    assign bus.ram_addr  = addr_q[RAM_AW-1:0];
    assign bus.ram_wdata = wdata_q;
    assign bus.spi_start = (state == EXT_START);
    assign bus.spi_we    = we_q;
    assign bus.spi_addr  = addr_q;
    assign bus.spi_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a synchronous RAM model and a
// programmable-delay external responder.
module tb_mem_access_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_access_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH_EXT(20), .INT_DEPTH(256)) bus ();

    mem_access_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH_EXT(20), .INT_DEPTH(256), .EXT_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.ram_re) bus.ram_rdata <= ram_mem[bus.ram_addr];
    end

    int n_ram_we = 0, n_ram_re = 0, n_spi_start = 0;
    logic [7:0] last_we_addr = '0;
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin n_ram_we++; last_we_addr = bus.ram_addr; end
        if (bus.ram_re === 1'b1) n_ram_re++;
        if (bus.spi_start === 1'b1) n_spi_start++;
    end

    int         spi_delay = -1;
    logic       resp_done = 1'b0, manual_done = 1'b0;
    logic [7:0] ext_data = 8'h00;
    assign bus.spi_done = resp_done | manual_done;

    initial begin
        bus.spi_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.spi_start === 1'b1) begin
                if (bus.spi_we) ext_data = bus.spi_wdata;
                if (spi_delay >= 0) begin
                    repeat (spi_delay) @(posedge clk);
                    #1 resp_done = 1'b1;
                    bus.spi_rdata = ext_data;
                    @(posedge clk);
                    #1 resp_done = 1'b0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Latency counts edges from the grant edge to the first edge that sees ack high.
    task automatic access(input bit is_alu, input bit we, input logic [19:0] addr,
                          input logic [7:0] wd, output int lat, output bit err,
                          output bit other);
        @(negedge clk);
        if (is_alu) begin
            bus.alu_req = 1'b1; bus.alu_we = we; bus.alu_addr = addr; bus.alu_wdata = wd;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
        end
        @(negedge clk);
        bus.cpu_req = 1'b0;
        bus.alu_req = 1'b0;
        lat = 1;
        while (((is_alu ? bus.alu_ack : bus.cpu_ack) !== 1'b1) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        err   = bus.ack_err;
        other = is_alu ? bus.cpu_ack : bus.alu_ack;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({bus.busy, bus.cpu_ack, bus.alu_ack, bus.ack_err} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                               {bus.busy, bus.cpu_ack, bus.alu_ack, bus.ack_err});
        end
        n_tests++;
        if ({bus.ram_we, bus.ram_re, bus.spi_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 000",
                               {bus.ram_we, bus.ram_re, bus.spi_start});
        end
        n_tests++;
        if ({bus.cpu_rdata, bus.alu_rdata} !== 16'h0000) begin
            n_fail++; $display("FAIL reset_rdata: got %h expected 0000",
                               {bus.cpu_rdata, bus.alu_rdata});
        end
    endtask

    task automatic test_ram_write_read();
        int lat; bit err, other; int we0, re0;
        we0 = n_ram_we; re0 = n_ram_re;
        access(1'b0, 1'b1, 20'h00010, 8'h55, lat, err, other);
        n_tests++;
        if (lat != 2) begin n_fail++; $display("FAIL ram_wr_lat: got %0d expected 2", lat); end
        n_tests++;
        if (n_ram_we - we0 != 1 || last_we_addr !== 8'h10) begin
            n_fail++; $display("FAIL ram_we_pulse: got %0d@%h expected 1@10",
                               n_ram_we - we0, last_we_addr);
        end
        n_tests++;
        if (bus.cpu_rdata !== 8'h00) begin
            n_fail++; $display("FAIL wr_keeps_rdata: got %h expected 00", bus.cpu_rdata);
        end
        access(1'b0, 1'b0, 20'h00010, 8'h00, lat, err, other);
        n_tests++;
        if (lat != 3) begin n_fail++; $display("FAIL ram_rd_lat: got %0d expected 3", lat); end
        n_tests++;
        if (bus.cpu_rdata !== 8'h55 || n_ram_re - re0 != 1) begin
            n_fail++; $display("FAIL ram_rd_data: got %h (%0d re) expected 55 (1 re)",
                               bus.cpu_rdata, n_ram_re - re0);
        end
    endtask

    task automatic test_round_robin();
        bit exp_alu; int wait_cnt;
        apply_reset();
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 20'h00020; bus.cpu_wdata = 8'h11;
        bus.alu_req = 1'b1; bus.alu_we = 1'b1; bus.alu_addr = 20'h00021; bus.alu_wdata = 8'h22;
        for (int i = 0; i < 3; i++) begin
            exp_alu = (i == 1);
            wait_cnt = 0;
            do begin
                @(negedge clk);
                wait_cnt++;
            end while (!(bus.cpu_ack === 1'b1 || bus.alu_ack === 1'b1) && wait_cnt < 50);
            n_tests++;
            if ({bus.cpu_ack, bus.alu_ack} !== {!exp_alu, exp_alu}) begin
                n_fail++; $display("FAIL rr_grant%0d: got acks %b expected %b", i,
                                   {bus.cpu_ack, bus.alu_ack}, {!exp_alu, exp_alu});
            end
            if (i == 2) begin bus.cpu_req = 1'b0; bus.alu_req = 1'b0; end
            @(negedge clk);
            n_tests++;
            if (bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL rr_idle_after_ack%0d: got busy %b expected 0", i, bus.busy);
            end
        end
        n_tests++;
        if (ram_mem[8'h20] !== 8'h11 || ram_mem[8'h21] !== 8'h22) begin
            n_fail++; $display("FAIL rr_data: got %h %h expected 11 22",
                               ram_mem[8'h20], ram_mem[8'h21]);
        end
    endtask

    task automatic test_ext_access();
        int lat; bit err, other; int st0;
        spi_delay = 5;
        st0 = n_spi_start;
        access(1'b1, 1'b1, 20'h00100, 8'hAA, lat, err, other);
        n_tests++;
        if (lat != 8 || err !== 1'b0 || other !== 1'b0) begin
            n_fail++; $display("FAIL ext_wr: got lat %0d err %b other %b expected 8 0 0",
                               lat, err, other);
        end
        n_tests++;
        if (n_spi_start - st0 != 1 || ext_data !== 8'hAA) begin
            n_fail++; $display("FAIL ext_wr_cmd: got %0d starts data %h expected 1 AA",
                               n_spi_start - st0, ext_data);
        end
        access(1'b1, 1'b0, 20'h00100, 8'h00, lat, err, other);
        n_tests++;
        if (lat != 8 || err !== 1'b0 || bus.alu_rdata !== 8'hAA) begin
            n_fail++; $display("FAIL ext_rd: got lat %0d err %b data %h expected 8 0 AA",
                               lat, err, bus.alu_rdata);
        end
        n_tests++;
        if (n_spi_start - st0 != 2 || bus.cpu_rdata !== 8'h00) begin
            n_fail++; $display("FAIL ext_rd_side: got %0d starts cpu_rdata %h expected 2 00",
                               n_spi_start - st0, bus.cpu_rdata);
        end
    endtask

    task automatic test_timeout();
        int lat; bit err, other;
        access(1'b0, 1'b0, 20'h00010, 8'h00, lat, err, other);
        spi_delay = -1;
        access(1'b0, 1'b0, 20'h12345, 8'h00, lat, err, other);
        n_tests++;
        if (lat != 18 || err !== 1'b1) begin
            n_fail++; $display("FAIL timeout: got lat %0d err %b expected 18 1", lat, err);
        end
        n_tests++;
        if (bus.cpu_rdata !== 8'h00) begin
            n_fail++; $display("FAIL timeout_rdata: got %h expected 00", bus.cpu_rdata);
        end
        spi_delay = 15;
        access(1'b0, 1'b0, 20'h12345, 8'h00, lat, err, other);
        n_tests++;
        if (lat != 18 || err !== 1'b0 || bus.cpu_rdata !== 8'hAA) begin
            n_fail++; $display("FAIL done_vs_timeout: got lat %0d err %b data %h expected 18 0 AA",
                               lat, err, bus.cpu_rdata);
        end
        spi_delay = 14;
        access(1'b0, 1'b1, 20'h54321, 8'h3C, lat, err, other);
        n_tests++;
        if (lat != 17 || err !== 1'b0 || bus.cpu_rdata !== 8'hAA) begin
            n_fail++; $display("FAIL ext_late_done: got lat %0d err %b data %h expected 17 0 AA",
                               lat, err, bus.cpu_rdata);
        end
    endtask

    task automatic test_reset_midop();
        int lat; bit err, other; bit seen_ack;
        spi_delay = -1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 20'h20000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL midop_busy: got %b expected 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({bus.busy, bus.cpu_ack, bus.alu_ack, bus.ack_err, bus.spi_start,
             bus.ram_we, bus.ram_re, bus.cpu_rdata, bus.alu_rdata} !== 23'h0) begin
            n_fail++; $display("FAIL midop_reset_outputs: got busy %b ack %b%b err %b rdata %h %h expected all 0",
                               bus.busy, bus.cpu_ack, bus.alu_ack, bus.ack_err,
                               bus.cpu_rdata, bus.alu_rdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        seen_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1 || bus.alu_ack === 1'b1 || bus.busy === 1'b1) seen_ack = 1'b1;
        end
        n_tests++;
        if (seen_ack !== 1'b0) begin
            n_fail++; $display("FAIL late_done_ignored: got activity %b expected 0", seen_ack);
        end
        access(1'b1, 1'b1, 20'h00030, 8'h77, lat, err, other);
        n_tests++;
        if (lat != 2 || ram_mem[8'h30] !== 8'h77) begin
            n_fail++; $display("FAIL after_reset_access: got lat %0d mem %h expected 2 77",
                               lat, ram_mem[8'h30]);
        end
    endtask

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.alu_req = 1'b0; bus.alu_we = 1'b0; bus.alu_addr = '0; bus.alu_wdata = '0;
        repeat (2) @(negedge clk);
        test_reset();
        reset = 1'b1;
        test_ram_write_read();
        test_round_robin();
        test_ext_access();
        test_timeout();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
